// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. It issues one instruction-memory read per
//   instruction and holds the returned word until the execute stage consumes
//   it. When the word is consumed, it computes the next PC from the
//   control-unit selection.
//
// Optional feature (compile-time macro FETCH_ALIGN_CHECK_EN):
//   If the macro is defined, a misaligned next PC (bits [1:0] != 0) moves the
//   unit into a terminal FAULT state. The unit stays there until reset.
//   If the macro is undefined, a misaligned next PC is used unchanged and
//   fault is tied low.
//
// Parameters
//   ADDR_W        PC and address width in bits
//   RESET_PC      PC value loaded on reset
//
// Ports
//   clk           clock; all state changes on its rising edge
//   rst           synchronous, active-high reset
//   pc_src        next-PC select: 00 PC+4, 01 PC-relative, 10 register, 11 PC+4
//   branch_offset sign-extended word offset for PC-relative branches
//   reg_target    register value used as the register branch target
//   imem_req      instruction-memory read request
//   imem_addr     read address (the fetch PC)
//   imem_ack      read-data-valid strobe, honoured only while fetching
//   imem_rdata    instruction word returned by memory
//   instr         held instruction word
//   instr_valid   instr holds an instruction not yet consumed
//   instr_ready   execute stage consumes instr this cycle
//   pc            address of the instruction held in instr
//   fault         misaligned-PC fault flag
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned           ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]     RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] branch_offset,
    input  logic [ADDR_W-1:0] reg_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              fault
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4'd4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
`ifdef FETCH_ALIGN_CHECK_EN
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
`else
        ST_HOLD  = 2'd2
`endif
    } fetch_state_t;

    // Next-PC selection. All arithmetic wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] calc_next_pc(
        input logic [ADDR_W-1:0] cur_pc,
        input logic [1:0]        sel,
        input logic [ADDR_W-1:0] offset,
        input logic [ADDR_W-1:0] target
    );
        logic [ADDR_W-1:0] result;
        case (sel)
            2'b01:   result = cur_pc + (offset << 2'd2);
            2'b10:   result = target;
            default: result = cur_pc + PC_STEP;
        endcase
        return result;
    endfunction

    fetch_state_t      state_r;
    fetch_state_t      state_next_s;
    logic [ADDR_W-1:0] fetch_pc_r;      // PC of the read being (or about to be) issued
    logic [ADDR_W-1:0] next_pc_s;
    logic              capture_s;       // memory word lands in instr this edge
    logic              consume_s;       // execute stage takes instr this edge
    logic [31:0]       instr_r;
    logic [ADDR_W-1:0] pc_r;
    logic              instr_valid_r;
    logic              imem_req_r;

    // Next-state and handshake decode.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        consume_s    = 1'b0;
        next_pc_s    = calc_next_pc(fetch_pc_r, pc_src, branch_offset, reg_target);
        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    consume_s = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (next_pc_s[1:0] != 2'b00) begin
                        state_next_s = ST_FAULT;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
`else
                    state_next_s = ST_FETCH;
`endif
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            ST_FAULT: begin
                state_next_s = ST_FAULT;
            end
`endif
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, PC and instruction registers. The request strobe is registered
    // from the next state, so it is high exactly while the unit is in FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            fetch_pc_r    <= RESET_PC;
            pc_r          <= RESET_PC;
            instr_r       <= 32'h0;
            instr_valid_r <= 1'b0;
            imem_req_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            imem_req_r <= (state_next_s == ST_FETCH);
            if (consume_s) begin
                fetch_pc_r <= next_pc_s;
            end
            if (capture_s) begin
                instr_r       <= imem_rdata;
                pc_r          <= fetch_pc_r;
                instr_valid_r <= 1'b1;
            end else if (consume_s) begin
                instr_valid_r <= 1'b0;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_r;

    // Fault flag. It is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= (state_next_s == ST_FAULT);
        end
    end

    assign fault = fault_r;
`else
    assign fault = 1'b0;
`endif

    assign imem_req    = imem_req_r;
    assign imem_addr   = fetch_pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign pc          = pc_r;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 64'h0, PC loaded on reset.
REQ-002 Parameter: ADDR_W, 64, PC and address width in bits.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: pc_src  in  2  next-PC select from control unit: 00 PC+4, 01 PC-relative branch, 10 register target, 11 treated as 00.
REQ-006 Port: branch_offset  in  ADDR_W  sign-extended word offset from sign-extend unit.
REQ-007 Port: reg_target  in  ADDR_W  register-file value used as the BR target.
REQ-008 Port: imem_req  out  1  instruction-memory read request.
REQ-009 Port: imem_addr  out  ADDR_W  read address; always equal to pc_q.
REQ-010 Port: imem_ack  in  1  read-data-valid strobe; zero or more wait states allowed.
REQ-011 Port: imem_rdata  in  32  instruction word; sampled only when imem_ack=1 in FETCH.
REQ-012 Port: instr  out  32  held instruction; bits [31:21] drive the control-unit opcode.
REQ-013 Port: instr_valid  out  1  instr holds an unexecuted instruction.
REQ-014 Port: instr_ready  in  1  execute stage consumes instr this cycle; pc_src, branch_offset and reg_target are valid in that same cycle.
REQ-015 Port: pc  out  ADDR_W  address of the instruction in instr.
REQ-016 Port: fault  out  1  misaligned-PC fault (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, HOLD and FAULT; FAULT exists only when the macro is defined.
REQ-018 IDLE SHALL go to FETCH unconditionally on the next edge, with imem_req=0.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL be pc_q, both stable until imem_ack.
REQ-020 In FETCH with imem_ack=1, the unit SHALL capture imem_rdata into instr and pc_q into pc, set instr_valid=1 and go to HOLD on the same edge.
REQ-021 Minimum latency is one cycle from imem_req rising to instr_valid (zero-wait ack); each wait state adds one cycle.
REQ-022 imem_ack SHALL be ignored outside FETCH.
REQ-023 In HOLD, instr, pc and instr_valid SHALL hold until instr_ready=1; imem_req SHALL be 0.
REQ-024 On a HOLD edge with instr_ready=1, the unit SHALL load pc_q with next_pc, clear instr_valid and go to FETCH.
REQ-025 next_pc SHALL be pc_q+4 for pc_src 00 or 11, pc_q+(branch_offset<<2) for 01, and reg_target for 10.
REQ-026 All next-PC arithmetic SHALL be modulo 2^ADDR_W; wrap past all-ones SHALL be silent.
REQ-027 instr_ready SHALL be ignored when instr_valid=0.
REQ-028 Throughput SHALL be at most one instruction per two cycles; back-to-back fetch without an intervening HOLD SHALL NOT occur.

Reset
REQ-029 With rst=1 at an edge, the unit SHALL set state=IDLE, pc_q=RESET_PC, pc=RESET_PC, instr=32'h0, instr_valid=0 and fault=0; imem_req SHALL then be 0.
REQ-030 rst SHALL override every other input, including a simultaneous imem_ack or instr_ready.
REQ-031 Reset mid-transaction SHALL abandon the outstanding read; a late imem_ack after reset SHALL be ignored because state is IDLE.

Configuration
REQ-032 With macro FETCH_ALIGN_CHECK_EN defined, a next_pc with bits [1:0]!=0 at a REQ-024 edge SHALL load pc_q with that value, go to FAULT and set fault=1.
REQ-033 In FAULT, imem_req=0, instr_valid=0 and fault=1 SHALL hold until reset.
REQ-034 Without FETCH_ALIGN_CHECK_EN, there SHALL be no FAULT state, fault SHALL be tied 0, and a misaligned next_pc SHALL be used unchanged.

Verification
REQ-035 Reset, then imem_ack tied 1, instr_ready tied 1, pc_src=00 -> imem_addr sequence 0,4,8,12; instr_valid pulses every second cycle.
REQ-036 imem_ack delayed 3 cycles -> imem_req and imem_addr held for 4 cycles; instr captured only on the ack edge.
REQ-037 pc=0x100, pc_src=01, branch_offset=-2 (all ones minus 1) -> next imem_addr 0xF8; pc=0xFFFF_FFFF_FFFF_FFFC, pc_src=00 -> imem_addr 0x0.
REQ-038 pc_src=10, reg_target=0x2000 -> next imem_addr 0x2000; with FETCH_ALIGN_CHECK_EN and reg_target=0x2002 -> fault=1 and imem_req stays 0 until rst.
REQ-039 rst asserted during a FETCH wait state, then imem_ack on the next cycle -> instr_valid stays 0 and imem_addr returns to RESET_PC.
REQ-040 Hold instr_ready=0 for 5 cycles in HOLD -> instr and pc unchanged, imem_req=0 throughout.
